register_file: RTL and testbench
================================

# register_file

32-entry × 32-bit general-purpose register file for the pipelined RISC datapath. It provides two combinational read ports (rs, rt) for the decode stage and one synchronous write port (rd) for write-back. An internal write-to-read bypass lets a register written in the current cycle be read in the same cycle without an extra forwarding path.

## Interface
- Clocking: one clock, `clk`; reset `rst_n` is asynchronous and active-low.
- Parameters:
  - `DATA_WIDTH`, default 32: register and data-port width.
  - `ADDR_WIDTH`, default 5: register address width; depth is 2^ADDR_WIDTH (32).
- Ports:
  - `clk` input 1: rising-edge clock for writes.
  - `rst_n` input 1: asynchronous active-low reset; clears all registers.
  - `rs_address` input ADDR_WIDTH: read port A address.
  - `rt_address` input ADDR_WIDTH: read port B address.
  - `rd_address` input ADDR_WIDTH: write address.
  - `rd_value` input DATA_WIDTH: write data.
  - `reg_write` input 1: write enable, active-high.
  - `rs_value` output DATA_WIDTH: read data for `rs_address`.
  - `rt_value` output DATA_WIDTH: read data for `rt_address`.

## Operation
- Storage: 2^ADDR_WIDTH registers of DATA_WIDTH bits.
- Register 0 is hardwired to zero:
  - Writes to address 0 are discarded.
  - Reads of address 0 always return 0, including during bypass.
- Write: on a rising `clk` edge with `rst_n`=1, `reg_write`=1 and `rd_address`≠0, `rd_value` is stored into reg[`rd_address`]. With `reg_write`=0 nothing changes.
- Read: `rs_value` and `rt_value` are purely combinational functions of their address, the stored array and the bypass inputs.
- Bypass (write-first), evaluated independently per read port:
  - If `reg_write`=1, `rd_address`≠0 and the read address equals `rd_address`, the port outputs `rd_value`.
  - Otherwise the port outputs the stored reg[address].
- Both ports may read the same address at once; both return the same value.
- No other state, no handshake, no error signalling.

## Timing
- Reset:
  - `rst_n` low clears all registers to 0 immediately, with no clock edge required.
  - While `rst_n` is low, `rs_value` and `rt_value` are 0 and the bypass is disabled.
  - Writes are blocked while `rst_n` is low, including a `clk` edge coincident with reset assertion.
  - After `rst_n` deasserts, the first rising edge may write.
- Read latency: zero cycles (combinational from address and data inputs).
- Write latency: data is visible through the bypass in the same cycle it is presented, and from the array from the first rising edge onward.
- Outputs glitch-free settling is not required; consumers sample on the next `clk` edge.
- Simultaneous write and read of the same register in one cycle: the read returns the new `rd_value`, never the old contents.
- Back-to-back writes to the same address: the last write wins at each edge.

## Test plan
- Reset:
  - Preload reg1=0xDEADBEEF, then drop `rst_n` asynchronously mid-cycle.
  - Required: `rs_value` (rs=1) is 0 immediately.
  - After release, reads of all 32 addresses return 0.
- Basic write/read:
  - `reg_write`=1, rd=1, `rd_value`=5, one edge; then rs=1.
  - Required: `rs_value`=5.
  - Then rd=31, `rd_value`=7, one edge; `reg_write`=0, rt=31.
  - Required: `rt_value`=7 and `rs_value` still 5.
- Register 0:
  - `reg_write`=1, rd=0, `rd_value`=0xFFFFFFFF, rs=0, rt=0, one edge.
  - Required: both outputs are 0 before and after the edge.
- Bypass:
  - reg3=0x11; in the next cycle drive `reg_write`=1, rd=3, `rd_value`=0x22, rs=3, rt=3.
  - Required: both outputs are 0x22 before the edge; 0x22 after the edge with `reg_write`=0.
- Write disable:
  - `reg_write`=0, rd=4, `rd_value`=0x99, two edges.
  - Required: reg4 reads 0.
  - Also, rs=4 with `reg_write`=0 must show no bypass.
- Full sweep:
  - Write reg[i]=i×0x01010101 for i=1..31.
  - Read every address on both ports in the same cycle.
  - Required: all values match; reg0=0.

Source files
------------

// File: rtl/register_file_if.sv
// Decode/write-back bus of the register file: two read ports (rs, rt) and one write port (rd).
// The master drives addresses and write data; the slave (the register file) returns read data.
`timescale 1ns/1ps
interface register_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] rs_address;
  logic [ADDR_WIDTH-1:0] rt_address;
  logic [ADDR_WIDTH-1:0] rd_address;
  logic [DATA_WIDTH-1:0] rd_value;
  logic                  reg_write;
  logic [DATA_WIDTH-1:0] rs_value;
  logic [DATA_WIDTH-1:0] rt_value;

  modport master (
    output rs_address,
    output rt_address,
    output rd_address,
    output rd_value,
    output reg_write,
    input  rs_value,
    input  rt_value
  );

  modport slave (
    input  rs_address,
    input  rt_address,
    input  rd_address,
    input  rd_value,
    input  reg_write,
    output rs_value,
    output rt_value
  );
endinterface

// File: rtl/register_file.sv
// 2^ADDR_WIDTH x DATA_WIDTH register file: two combinational write-first read ports, one
// synchronous write port, register 0 hardwired to zero, asynchronous active-low clear.
`timescale 1ns/1ps
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  register_file_if.slave rf
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int NUM_READ_PORTS = 2;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic                  wr_en;

  // Address 0 never qualifies as a write, so entry 0 stays at its reset value forever.
  assign wr_en = rf.reg_write && (rf.rd_address != '0);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_en && (rf.rd_address == ADDR_WIDTH'(i))) begin
        regs_d[i] = rf.rd_value;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_READ_PORTS; gi++) begin : g_read
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;

      assign addr = (gi == 0) ? rf.rs_address : rf.rt_address;

      // Outputs are forced to zero while in reset so a pending bypass cannot leak through.
      always_comb begin
        data = '0;
        if (rst_n && (addr != '0)) begin
          if (wr_en && (addr == rf.rd_address)) begin
            data = rf.rd_value;
          end else begin
            data = regs_q[addr];
          end
        end
      end
    end
  endgenerate

  assign rf.rs_value = g_read[0].data;
  assign rf.rt_value = g_read[1].data;

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file: reset, write/read, register 0, bypass,
// write disable, back-to-back writes and a full sweep of both read ports.
`timescale 1ns/1ps
module tb_register_file;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) rf_if ();

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rf    (rf_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

  // Present a write at the falling edge, commit it on the next rising edge.
  task automatic write_reg(input logic [4:0] addr, input logic [31:0] val);
    @(negedge clk);
    rf_if.reg_write  = 1'b1;
    rf_if.rd_address = addr;
    rf_if.rd_value   = val;
    @(posedge clk);
    #1;
    rf_if.reg_write = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] exp_v;
    write_reg(5'd1, 32'hDEADBEEF);
    @(negedge clk);
    rf_if.rs_address = 5'd1;
    #1;
    checks++;
    if (rf_if.rs_value !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL reset_preload: rs_value=%h expected=%h", rf_if.rs_value, 32'hDEADBEEF);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (rf_if.rs_value !== 32'h0) begin
      errors++;
      $display("FAIL reset_async_clear: rs_value=%h expected=%h", rf_if.rs_value, 32'h0);
    end
    rf_if.reg_write  = 1'b1;
    rf_if.rd_address = 5'd2;
    rf_if.rd_value   = 32'h12345678;
    rf_if.rt_address = 5'd2;
    #1;
    checks++;
    if (rf_if.rt_value !== 32'h0) begin
      errors++;
      $display("FAIL reset_bypass_disabled: rt_value=%h expected=%h", rf_if.rt_value, 32'h0);
    end
    @(posedge clk);
    #1;
    rf_if.reg_write = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_v = 32'h0;
    for (int a = 0; a < 32; a++) begin
      rf_if.rs_address = 5'(a);
      rf_if.rt_address = 5'(31 - a);
      #1;
      checks++;
      if (rf_if.rs_value !== exp_v || rf_if.rt_value !== exp_v) begin
        errors++;
        $display("FAIL reset_sweep addr=%0d: rs_value=%h rt_value=%h expected=%h",
                 a, rf_if.rs_value, rf_if.rt_value, exp_v);
      end
    end
    $display("test_reset done: errors=%0d", errors);
  endtask

  task automatic test_basic();
    write_reg(5'd1, 32'd5);
    rf_if.rs_address = 5'd1;
    #1;
    checks++;
    if (rf_if.rs_value !== 32'd5) begin
      errors++;
      $display("FAIL basic_rs1: rs_value=%h expected=%h", rf_if.rs_value, 32'd5);
    end
    write_reg(5'd31, 32'd7);
    rf_if.rt_address = 5'd31;
    #1;
    checks++;
    if (rf_if.rt_value !== 32'd7 || rf_if.rs_value !== 32'd5) begin
      errors++;
      $display("FAIL basic_rt31: rt_value=%h expected=%h rs_value=%h expected=%h",
               rf_if.rt_value, 32'd7, rf_if.rs_value, 32'd5);
    end
    $display("test_basic done: errors=%0d", errors);
  endtask

  task automatic test_reg0();
    @(negedge clk);
    rf_if.reg_write  = 1'b1;
    rf_if.rd_address = 5'd0;
    rf_if.rd_value   = 32'hFFFFFFFF;
    rf_if.rs_address = 5'd0;
    rf_if.rt_address = 5'd0;
    #1;
    checks++;
    if (rf_if.rs_value !== 32'h0 || rf_if.rt_value !== 32'h0) begin
      errors++;
      $display("FAIL reg0_before_edge: rs_value=%h rt_value=%h expected=0",
               rf_if.rs_value, rf_if.rt_value);
    end
    @(posedge clk);
    #1;
    checks++;
    if (rf_if.rs_value !== 32'h0 || rf_if.rt_value !== 32'h0) begin
      errors++;
      $display("FAIL reg0_after_edge: rs_value=%h rt_value=%h expected=0",
               rf_if.rs_value, rf_if.rt_value);
    end
    rf_if.reg_write = 1'b0;
    $display("test_reg0 done: errors=%0d", errors);
  endtask

  task automatic test_bypass();
    write_reg(5'd3, 32'h11);
    @(negedge clk);
    rf_if.rs_address = 5'd3;
    rf_if.rt_address = 5'd1;
    #1;
    checks++;
    if (rf_if.rs_value !== 32'h11) begin
      errors++;
      $display("FAIL bypass_old_value: rs_value=%h expected=%h", rf_if.rs_value, 32'h11);
    end
    rf_if.reg_write  = 1'b1;
    rf_if.rd_address = 5'd3;
    rf_if.rd_value   = 32'h22;
    rf_if.rt_address = 5'd3;
    #1;
    checks++;
    if (rf_if.rs_value !== 32'h22 || rf_if.rt_value !== 32'h22) begin
      errors++;
      $display("FAIL bypass_same_cycle: rs_value=%h rt_value=%h expected=%h",
               rf_if.rs_value, rf_if.rt_value, 32'h22);
    end
    @(posedge clk);
    #1;
    rf_if.reg_write = 1'b0;
    #1;
    checks++;
    if (rf_if.rs_value !== 32'h22 || rf_if.rt_value !== 32'h22) begin
      errors++;
      $display("FAIL bypass_after_edge: rs_value=%h rt_value=%h expected=%h",
               rf_if.rs_value, rf_if.rt_value, 32'h22);
    end
    // Bypass only on the matching port: rs hits rd, rt reads stored reg1.
    rf_if.reg_write  = 1'b1;
    rf_if.rd_address = 5'd6;
    rf_if.rd_value   = 32'h66;
    rf_if.rs_address = 5'd6;
    rf_if.rt_address = 5'd1;
    #1;
    checks++;
    if (rf_if.rs_value !== 32'h66 || rf_if.rt_value !== 32'd5) begin
      errors++;
      $display("FAIL bypass_per_port: rs_value=%h expected=%h rt_value=%h expected=%h",
               rf_if.rs_value, 32'h66, rf_if.rt_value, 32'd5);
    end
    rf_if.reg_write = 1'b0;
    #1;
    checks++;
    if (rf_if.rs_value !== 32'h0) begin
      errors++;
      $display("FAIL bypass_withdrawn: rs_value=%h expected=%h", rf_if.rs_value, 32'h0);
    end
    $display("test_bypass done: errors=%0d", errors);
  endtask

  task automatic test_write_disable();
    @(negedge clk);
    rf_if.reg_write  = 1'b0;
    rf_if.rd_address = 5'd4;
    rf_if.rd_value   = 32'h99;
    rf_if.rs_address = 5'd4;
    #1;
    checks++;
    if (rf_if.rs_value !== 32'h0) begin
      errors++;
      $display("FAIL wdis_no_bypass: rs_value=%h expected=%h", rf_if.rs_value, 32'h0);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (rf_if.rs_value !== 32'h0) begin
      errors++;
      $display("FAIL wdis_reg4: rs_value=%h expected=%h", rf_if.rs_value, 32'h0);
    end
    $display("test_write_disable done: errors=%0d", errors);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    rf_if.reg_write  = 1'b1;
    rf_if.rd_address = 5'd5;
    rf_if.rd_value   = 32'hA;
    @(negedge clk);
    rf_if.rd_value   = 32'hB;
    rf_if.rs_address = 5'd7;
    rf_if.rt_address = 5'd5;
    rf_if.rd_address = 5'd5;
    @(posedge clk);
    #1;
    rf_if.reg_write = 1'b0;
    #1;
    checks++;
    if (rf_if.rt_value !== 32'hB) begin
      errors++;
      $display("FAIL b2b_last_wins: rt_value=%h expected=%h", rf_if.rt_value, 32'hB);
    end
    $display("test_back_to_back done: errors=%0d", errors);
  endtask

  task automatic test_full_sweep();
    logic [31:0] exp_v;
    for (int i = 1; i < 32; i++) begin
      write_reg(5'(i), 32'(i) * 32'h01010101);
    end
    @(negedge clk);
    for (int a = 0; a < 32; a++) begin
      rf_if.rs_address = 5'(a);
      rf_if.rt_address = 5'(a);
      exp_v = 32'(a) * 32'h01010101;
      #1;
      checks++;
      if (rf_if.rs_value !== exp_v || rf_if.rt_value !== exp_v) begin
        errors++;
        $display("FAIL sweep addr=%0d: rs_value=%h rt_value=%h expected=%h",
                 a, rf_if.rs_value, rf_if.rt_value, exp_v);
      end
    end
    // Cross-read: the two ports on different addresses in the same cycle.
    rf_if.rs_address = 5'd9;
    rf_if.rt_address = 5'd30;
    #1;
    checks++;
    if (rf_if.rs_value !== 32'h09090909 || rf_if.rt_value !== 32'h1E1E1E1E) begin
      errors++;
      $display("FAIL sweep_cross: rs_value=%h expected=%h rt_value=%h expected=%h",
               rf_if.rs_value, 32'h09090909, rf_if.rt_value, 32'h1E1E1E1E);
    end
    $display("test_full_sweep done: errors=%0d", errors);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    rf_if.rs_address = '0;
    rf_if.rt_address = '0;
    rf_if.rd_address = '0;
    rf_if.rd_value   = '0;
    rf_if.reg_write  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    test_reset();
    test_basic();
    test_reg0();
    test_bypass();
    test_write_disable();
    test_back_to_back();
    test_full_sweep();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
